fetch_unit: RTL and testbench

- Instruction-fetch sequencer directly downstream of the PC register.
- Consumes the current PC value, issues the memory read (MAR<-PC), pulses PC load with the increment select (PC<-PC+1), latches the returned word into IR, and hands it to decode through a valid/ack handshake.
- Decode/execute can redirect it on branch, jump or trap.

---
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer sitting right after the PC register.
// It issues the memory read for the current PC, pulses the PC increment load,
// latches the returned word into IR and presents it to decode via valid/ack.
// Branch/jump/trap redirects abandon the fetch in flight. Any read already
// issued is allowed to finish, and its data is then dropped.
// Optional build macro FETCH_TIMEOUT_EN adds a WAIT-cycle watchdog with a
// sticky fetch_err flag. Without the macro, WAIT lasts until mem_ready and
// fetch_err is tied low.

module fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              ld_pc,
    output logic [1:0]        sel_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              instr_valid,
    input  logic              instr_ack,
    input  logic              redirect,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t            state_q;
    logic              ld_pc_q;
    logic              mem_rd_q;
    logic              valid_q;
    logic              discard_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] ir_pc_q;
    logic [DATA_W-1:0] ir_q;

    logic              issue_d;
    logic [ADDR_W-1:0] ir_pc_d;
    logic              fetch_blocked;

    // The watchdog count is 8 bits wide, so anything outside 1..255 cannot work.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("fetch_unit: TIMEOUT must lie in 1..255");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    logic       err_q;
    logic [7:0] count_q;

    assign fetch_blocked = err_q;
    assign fetch_err     = err_q;
`else
    assign fetch_blocked = 1'b0;
    assign fetch_err     = 1'b0;
`endif

    assign ld_pc       = ld_pc_q;
    assign sel_pc      = 2'b00;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign instr_valid = valid_q;

    // The incremented PC wraps naturally at the address width.
    assign ir_pc_d = pc_in + ADDR_W'(1);

    // Decide whether a new read starts this cycle: from IDLE, or directly out of HOLD on ack.
    always_comb begin
        issue_d = 1'b0;
        case (state_q)
            IDLE:    issue_d = enable && !redirect && !fetch_blocked;
            HOLD:    issue_d = instr_ack && !redirect && enable && !fetch_blocked;
            default: issue_d = 1'b0;
        endcase
    end

    // Fetch sequencer: every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ld_pc_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            valid_q    <= 1'b0;
            discard_q  <= 1'b0;
            mem_addr_q <= '0;
            ir_pc_q    <= '0;
            ir_q       <= '0;
`ifdef FETCH_TIMEOUT_EN
            err_q      <= 1'b0;
            count_q    <= '0;
`endif
        end else begin
            ld_pc_q <= 1'b0;
            if (issue_d) begin
                state_q    <= WAIT;
                mem_addr_q <= pc_in;
                ir_pc_q    <= ir_pc_d;
                mem_rd_q   <= 1'b1;
                ld_pc_q    <= 1'b1;
                valid_q    <= 1'b0;
                discard_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                count_q    <= '0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    WAIT: begin
                        if (mem_ready) begin
                            mem_rd_q <= 1'b0;
                            if (discard_q || redirect) begin
                                discard_q <= 1'b0;
                                state_q   <= IDLE;
                            end else begin
                                ir_q    <= mem_rdata;
                                valid_q <= 1'b1;
                                state_q <= HOLD;
                            end
                        end else begin
                            if (redirect) begin
                                discard_q <= 1'b1;
                            end
`ifdef FETCH_TIMEOUT_EN
                            if (count_q == COUNT_LAST) begin
                                mem_rd_q  <= 1'b0;
                                err_q     <= 1'b1;
                                discard_q <= 1'b0;
                                state_q   <= IDLE;
                            end else begin
                                count_q <= count_q + 8'd1;
                            end
`endif
                        end
                    end
                    HOLD: begin
                        if (redirect || instr_ack) begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit with a cycle-level reference
// model and hand-computed literal checkpoints. Define FETCH_TIMEOUT_EN to
// exercise the watchdog. The DUT is built with TIMEOUT=4.

module tb_fetch_unit;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] pc_in;
    logic        ld_pc;
    logic [1:0]  sel_pc;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        instr_valid;
    logic        instr_ack;
    logic        redirect;
    logic        fetch_err;

    int total;
    int bad;
    int ldPulses;
    int validCycles;

    fetch_unit #(
        .ADDR_W (16),
        .DATA_W (16),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pc_in      (pc_in),
        .ld_pc      (ld_pc),
        .sel_pc     (sel_pc),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .instr_valid(instr_valid),
        .instr_ack  (instr_ack),
        .redirect   (redirect),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the expected registered outputs plus a pending-drop flag.
    logic        modelLive;
    logic        eLdPc;
    logic        eMemRd;
    logic        eValid;
    logic        eErr;
    logic        dropData;
    logic [15:0] eMemAddr;
    logic [15:0] eIrPc;
    logic [15:0] eIr;
    logic        issueNow;
`ifdef FETCH_TIMEOUT_EN
    int          waitCount;
`endif

    initial modelLive = 1'b0;

    // A read starts when nothing is outstanding, no error is latched, the unit
    // is enabled, no redirect is present, and any held word is being acked.
    always_comb begin
        issueNow = 1'b0;
        if (!reset && !eMemRd && enable && !eErr && !redirect)
            issueNow = eValid ? instr_ack : 1'b1;
    end

    always @(posedge clk) begin
        eLdPc <= 1'b0;
        if (reset) begin
            modelLive <= 1'b1;
            eMemRd    <= 1'b0;
            eValid    <= 1'b0;
            eErr      <= 1'b0;
            dropData  <= 1'b0;
            eMemAddr  <= 16'h0000;
            eIrPc     <= 16'h0000;
            eIr       <= 16'h0000;
`ifdef FETCH_TIMEOUT_EN
            waitCount <= 0;
`endif
        end else begin
            if (eMemRd) begin
                if (mem_ready) begin
                    eMemRd <= 1'b0;
                    if (dropData || redirect) begin
                        dropData <= 1'b0;
                    end else begin
                        eIr    <= mem_rdata;
                        eValid <= 1'b1;
                    end
                end else begin
                    if (redirect) dropData <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    waitCount <= waitCount + 1;
                    if (waitCount + 1 == TB_TIMEOUT) begin
                        eMemRd   <= 1'b0;
                        eErr     <= 1'b1;
                        dropData <= 1'b0;
                    end
`endif
                end
            end else if (eValid && (redirect || instr_ack)) begin
                eValid <= 1'b0;
            end
            if (issueNow) begin
                eMemAddr <= pc_in;
                eIrPc    <= pc_in + 16'd1;
                eMemRd   <= 1'b1;
                eLdPc    <= 1'b1;
                dropData <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                waitCount <= 0;
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Every falling edge after reset, all outputs must match the model.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("cyc ld_pc",       32'(ld_pc),       32'(eLdPc));
            checkOutput("cyc sel_pc",      32'(sel_pc),      32'(2'b00));
            checkOutput("cyc mem_rd",      32'(mem_rd),      32'(eMemRd));
            checkOutput("cyc mem_addr",    32'(mem_addr),    32'(eMemAddr));
            checkOutput("cyc ir",          32'(ir),          32'(eIr));
            checkOutput("cyc ir_pc",       32'(ir_pc),       32'(eIrPc));
            checkOutput("cyc instr_valid", 32'(instr_valid), 32'(eValid));
            checkOutput("cyc fetch_err",   32'(fetch_err),   32'(eErr));
        end
    end

    // Drive one cycle of inputs, let the edge happen, then settle 1 time unit.
    task automatic applyStimulus(input logic en, input logic [15:0] pc, input logic rdy,
                                 input logic [15:0] rdata, input logic ack, input logic redir);
        enable    = en;
        pc_in     = pc;
        mem_ready = rdy;
        mem_rdata = rdata;
        instr_ack = ack;
        redirect  = redir;
        @(posedge clk);
        #1;
        if (ld_pc === 1'b1) ldPulses++;
        if (instr_valid === 1'b1) validCycles++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        ldPulses = 0;
        validCycles = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("reset mem_rd",      32'(mem_rd),      32'h0);
        checkOutput("reset instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("reset mem_addr",    32'(mem_addr),    32'h0);
        checkOutput("reset ir",          32'(ir),          32'h0);
        checkOutput("reset fetch_err",   32'(fetch_err),   32'h0);
        reset = 1'b0;

        $display("[TB] single fetch at 3000 with one wait cycle");
        applyStimulus(1'b1, 16'h3000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("t1 ld_pc",    32'(ld_pc),    32'h1);
        checkOutput("t1 mem_rd",   32'(mem_rd),   32'h1);
        checkOutput("t1 mem_addr", 32'(mem_addr), 32'h3000);
        applyStimulus(1'b0, 16'h3001, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("t1 ld_pc drop", 32'(ld_pc),  32'h0);
        checkOutput("t1 mem_rd hold", 32'(mem_rd), 32'h1);
        applyStimulus(1'b0, 16'h3001, 1'b1, 16'h1261, 1'b0, 1'b0);
        checkOutput("t1 ir",    32'(ir),          32'h1261);
        checkOutput("t1 ir_pc", 32'(ir_pc),       32'h3001);
        checkOutput("t1 valid", 32'(instr_valid), 32'h1);
        applyStimulus(1'b0, 16'h3001, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("t1 valid held", 32'(instr_valid), 32'h1);
        applyStimulus(1'b0, 16'h3001, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("t1 valid acked", 32'(instr_valid), 32'h0);

        $display("[TB] three back-to-back zero-wait fetches");
        ldPulses = 0;
        validCycles = 0;
        applyStimulus(1'b1, 16'h3000, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h3001, 1'b1, 16'hAAA0, 1'b0, 1'b0);
        checkOutput("t2 ir_pc 0", 32'(ir_pc), 32'h3001);
        applyStimulus(1'b1, 16'h3001, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("t2 addr 1", 32'(mem_addr), 32'h3001);
        applyStimulus(1'b1, 16'h3002, 1'b1, 16'hAAA1, 1'b0, 1'b0);
        checkOutput("t2 ir_pc 1", 32'(ir_pc), 32'h3002);
        applyStimulus(1'b1, 16'h3002, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h3003, 1'b1, 16'hAAA2, 1'b0, 1'b0);
        checkOutput("t2 ir_pc 2", 32'(ir_pc), 32'h3003);
        applyStimulus(1'b0, 16'h3003, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("t2 ld pulses",  32'(ldPulses),    32'd3);
        checkOutput("t2 valid cycles", 32'(validCycles), 32'd3);

        $display("[TB] redirect during WAIT drops the returning word");
        applyStimulus(1'b1, 16'h3005, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h4000, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        checkOutput("t3 valid", 32'(instr_valid), 32'h0);
        checkOutput("t3 ir kept", 32'(ir), 32'hAAA2);
        checkOutput("t3 mem_rd", 32'(mem_rd), 32'h0);
        applyStimulus(1'b1, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("t3 new addr", 32'(mem_addr), 32'h4000);
        checkOutput("t3 new ir_pc", 32'(ir_pc), 32'h4001);
        applyStimulus(1'b0, 16'h4001, 1'b1, 16'h1234, 1'b0, 1'b0);

        $display("[TB] ack and redirect together in HOLD");
        applyStimulus(1'b1, 16'h4001, 1'b0, 16'h0000, 1'b1, 1'b1);
        checkOutput("t4 valid", 32'(instr_valid), 32'h0);
        checkOutput("t4 ld_pc", 32'(ld_pc), 32'h0);
        checkOutput("t4 mem_rd", 32'(mem_rd), 32'h0);
        applyStimulus(1'b1, 16'h5000, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("t4 idle redirect addr", 32'(mem_addr), 32'h4000);
        applyStimulus(1'b0, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("t4 stray ack", 32'(instr_valid), 32'h0);

        $display("[TB] PC wrap and reset mid-WAIT");
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("t5 ir_pc wrap", 32'(ir_pc), 32'h0000);
        checkOutput("t5 addr", 32'(mem_addr), 32'hFFFF);
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("t5 rst mem_rd", 32'(mem_rd), 32'h0);
        checkOutput("t5 rst ir_pc", 32'(ir_pc), 32'h0);
        checkOutput("t5 rst addr", 32'(mem_addr), 32'h0);
        reset = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        $display("[TB] watchdog expiry with no mem_ready");
        applyStimulus(1'b1, 16'h6000, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b0, 1'b0);
            checkOutput("t6 mem_rd waiting", 32'(mem_rd), 32'h1);
        end
        applyStimulus(1'b1, 16'h6001, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("t6 mem_rd timeout", 32'(mem_rd), 32'h0);
        checkOutput("t6 fetch_err set", 32'(fetch_err), 32'h1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h6001, 1'b0, 16'h0000, 1'b0, 1'b0);
            checkOutput("t6 no new fetch", 32'(mem_rd), 32'h0);
            checkOutput("t6 fetch_err sticky", 32'(fetch_err), 32'h1);
        end
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("t6 fetch_err cleared", 32'(fetch_err), 32'h0);
        reset = 1'b0;
`else
        $display("[TB] long WAIT without watchdog");
        applyStimulus(1'b1, 16'h6000, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b0, 1'b0);
            checkOutput("t6 mem_rd waiting", 32'(mem_rd), 32'h1);
        end
        applyStimulus(1'b0, 16'h6001, 1'b1, 16'h5A5A, 1'b0, 1'b0);
        checkOutput("t6 ir late", 32'(ir), 32'h5A5A);
        checkOutput("t6 fetch_err low", 32'(fetch_err), 32'h0);
        applyStimulus(1'b0, 16'h6001, 1'b0, 16'h0000, 1'b1, 1'b0);
`endif
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
